// File: rtl/ws2812_frame_sequencer_if.sv
// ws2812_frame_sequencer_if: handshake and position signals between a WS2812B
// frame sequencer and its client (bit generator and pixel source).
`timescale 1ns/1ps
interface ws2812_frame_sequencer_if #(
  parameter int NUM_LEDS     = 4,
  parameter int BITS_PER_LED = 24
);
  localparam int BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic             start;
  logic             abort;
  logic             genDone;
  logic [BIT_W-1:0] bitIdx;
  logic [LED_W-1:0] ledIdx;
  logic             pixelReq;
  logic             busy;
  logic             sendEnable;
  logic             latchActive;
  logic             sendDone;

  modport master (
    output start, abort, genDone,
    input  bitIdx, ledIdx, pixelReq, busy, sendEnable, latchActive, sendDone
  );

  modport slave (
    input  start, abort, genDone,
    output bitIdx, ledIdx, pixelReq, busy, sendEnable, latchActive, sendDone
  );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer: counts finished bits into bit/LED positions, asks for
// the next pixel word at each LED boundary, then holds the WS2812B latch period
// and reports frame completion. Optionally refreshes the chain continuously.
`timescale 1ns/1ps
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS     = 4,
  parameter int BITS_PER_LED = 24,
  parameter int LATCH_CYCLES = 5000,
  parameter int CONTINUOUS   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  ws2812_frame_sequencer_if.slave   bus
);

  localparam int BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_LED - 1);
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } stateT;

  stateT            stateQ, stateD;
  logic [BIT_W-1:0] bitIdxQ, bitIdxD;
  logic [LED_W-1:0] ledIdxQ, ledIdxD;
  logic [LAT_W-1:0] latchCntQ, latchCntD;
  logic             pixelReqQ, pixelReqD;
  logic             busyQ, busyD;
  logic             sendEnableQ, sendEnableD;
  logic             latchActiveQ, latchActiveD;
  logic             sendDoneQ, sendDoneD;

  // State, counters and every output live in flops; reset clears them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ       <= IDLE;
      bitIdxQ      <= '0;
      ledIdxQ      <= '0;
      latchCntQ    <= '0;
      pixelReqQ    <= 1'b0;
      busyQ        <= 1'b0;
      sendEnableQ  <= 1'b0;
      latchActiveQ <= 1'b0;
      sendDoneQ    <= 1'b0;
    end else begin
      stateQ       <= stateD;
      bitIdxQ      <= bitIdxD;
      ledIdxQ      <= ledIdxD;
      latchCntQ    <= latchCntD;
      pixelReqQ    <= pixelReqD;
      busyQ        <= busyD;
      sendEnableQ  <= sendEnableD;
      latchActiveQ <= latchActiveD;
      sendDoneQ    <= sendDoneD;
    end
  end

  // Next state and next register values; abort outranks genDone and latch expiry.
  always_comb begin
    stateD    = stateQ;
    bitIdxD   = bitIdxQ;
    ledIdxD   = ledIdxQ;
    latchCntD = latchCntQ;
    pixelReqD = 1'b0;
    sendDoneD = 1'b0;

    case (stateQ)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          stateD    = SEND;
          bitIdxD   = '0;
          ledIdxD   = '0;
          latchCntD = '0;
          pixelReqD = 1'b1;
        end
      end

      SEND: begin
        if (bus.abort) begin
          stateD    = IDLE;
          bitIdxD   = '0;
          ledIdxD   = '0;
          latchCntD = '0;
        end else if (bus.genDone) begin
          if (bitIdxQ != BIT_LAST) begin
            bitIdxD = bitIdxQ + 1'b1;
          end else begin
            bitIdxD = '0;
            if (ledIdxQ != LED_LAST) begin
              ledIdxD   = ledIdxQ + 1'b1;
              pixelReqD = 1'b1;
            end else begin
              ledIdxD   = '0;
              latchCntD = '0;
              stateD    = LATCH;
            end
          end
        end
      end

      LATCH: begin
        if (bus.abort) begin
          stateD    = IDLE;
          bitIdxD   = '0;
          ledIdxD   = '0;
          latchCntD = '0;
        end else if (latchCntQ == LAT_LAST) begin
          latchCntD = '0;
          sendDoneD = 1'b1;
          bitIdxD   = '0;
          ledIdxD   = '0;
          if (CONTINUOUS != 0) begin
            stateD    = SEND;
            pixelReqD = 1'b1;
          end else begin
            stateD = IDLE;
          end
        end else begin
          latchCntD = latchCntQ + 1'b1;
        end
      end

      default: begin
        stateD    = IDLE;
        bitIdxD   = '0;
        ledIdxD   = '0;
        latchCntD = '0;
      end
    endcase

    busyD        = (stateD != IDLE);
    sendEnableD  = (stateD == SEND);
    latchActiveD = (stateD == LATCH);
  end

  assign bus.bitIdx      = bitIdxQ;
  assign bus.ledIdx      = ledIdxQ;
  assign bus.pixelReq    = pixelReqQ;
  assign bus.busy        = busyQ;
  assign bus.sendEnable  = sendEnableQ;
  assign bus.latchActive = latchActiveQ;
  assign bus.sendDone    = sendDoneQ;

endmodule
